pe5_row_ctrl: RTL and testbench

Sequencer for one 5-tap systolic PE row: five PEs with the input sample broadcast to all taps and the partial sum chained through them.
- Loads the five 8-bit tap weights through a valid/ready port and holds them stable during compute.
- Streams a row of LEN input samples into the row with contiguous timing.
- Tracks the PE pipeline latency and flags which chain outputs are valid convolution results.
- Pulses done at the end of each row.

---
 rtl/pe_pkg.sv | 30 +++
 rtl/pe_valid_pipe.sv | 42 ++++
 rtl/pe5_row_ctrl.sv | 172 +++++++++++++++++
 tb/tb_pe5_row_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared definitions for the 5-tap systolic PE row: FSM states, tap count,
// datapath widths and the per-tap output width of the PE chain.
package pe_pkg;

  // Row sequencer states
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_RUN    = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Tap count equals the physical PE count of the row
  localparam int unsigned TAPS   = 5;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned PSUM_W = 16;

  // Width of the partial sum leaving a given tap (1-based). Growth is
  // scheduled so the final tap carries the full 5-term accumulation.
  function automatic int unsigned pe_out_w(input int unsigned tap);
    case (tap)
      1, 2:    return 17;
      3, 4:    return 18;
      5:       return 19;
      default: return PSUM_W;
    endcase
  endfunction

endpackage

// File: rtl/pe_valid_pipe.sv
// Valid/index shift register that mirrors the PE row latency. Each stage
// carries a slot-valid bit and the sample index of that slot; the final
// stage is the registered result-valid flag, suppressing warm-up slots
// whose index is below MIN_IDX.
module pe_valid_pipe #(
  parameter int unsigned DEPTH   = 6,
  parameter int unsigned IDX_W   = 6,
  parameter int unsigned MIN_IDX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid
);

  // DEPTH-1 tracking stages plus the qualified output register
  localparam int unsigned NSTG = DEPTH - 1;

  logic [NSTG-1:0]  vld;
  logic [IDX_W-1:0] idx [NSTG];

  // Shift slot markers toward the chain output and qualify the tail
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld       <= '0;
      out_valid <= 1'b0;
      for (int k = 0; k < int'(NSTG); k++) begin
        idx[k] <= '0;
      end
    end else begin
      vld[0] <= in_valid;
      idx[0] <= in_idx;
      for (int k = 1; k < int'(NSTG); k++) begin
        vld[k] <= vld[k-1];
        idx[k] <= idx[k-1];
      end
      out_valid <= vld[NSTG-1] && (idx[NSTG-1] >= IDX_W'(MIN_IDX));
    end
  end

endmodule

// File: rtl/pe5_row_ctrl.sv
// Sequencer for one 5-tap systolic PE row: loads tap weights, streams a row
// of LEN samples with no stalls, tracks result validity through the PE
// latency and pulses done at row end.
// Optional feature macro: PE5_ROW_CTRL_BIAS_EN -- adds a sixth load beat
// carrying a signed bias that seeds the partial-sum chain.
module pe5_row_ctrl
  import pe_pkg::*;
#(
  parameter int unsigned LEN   = 32,
  parameter int unsigned LAT   = 5,
  parameter int unsigned CNT_W = 6
) (
  input  logic                     iCLK,
  input  logic                     iRST,
  input  logic                     iStart,
  input  logic signed [DATA_W-1:0] iW_data,
  input  logic                     iW_valid,
  output logic                     oW_ready,
  input  logic signed [DATA_W-1:0] iX_data,
  input  logic                     iX_valid,
  output logic                     oX_ready,
  output logic signed [DATA_W-1:0] oW1,
  output logic signed [DATA_W-1:0] oW2,
  output logic signed [DATA_W-1:0] oW3,
  output logic signed [DATA_W-1:0] oW4,
  output logic signed [DATA_W-1:0] oW5,
  output logic signed [DATA_W-1:0] oX,
  output logic signed [PSUM_W-1:0] oPsum_init,
  output logic                     oY_valid,
  output logic                     oBusy,
  output logic                     oDone,
  output logic                     oErr
);

`ifdef PE5_ROW_CTRL_BIAS_EN
  localparam int unsigned LOAD_BEATS = TAPS + 1;
`else
  localparam int unsigned LOAD_BEATS = TAPS;
`endif

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             run_slot_c;
  logic             bias_beat_c;

  // Every RUN cycle is a sample slot, bubbles included
  assign run_slot_c = (state == S_RUN);

  // The beat after the last tap weight carries the bias when enabled
`ifdef PE5_ROW_CTRL_BIAS_EN
  assign bias_beat_c = (cnt == CNT_W'(TAPS));
`else
  assign bias_beat_c = 1'b0;
  assign oPsum_init  = '0;
`endif

  // Result-valid tracking through the PE row latency
  pe_valid_pipe #(
    .DEPTH   (LAT + 1),
    .IDX_W   (CNT_W),
    .MIN_IDX (TAPS - 1)
  ) u_vpipe (
    .clk       (iCLK),
    .rst       (iRST),
    .in_valid  (run_slot_c),
    .in_idx    (cnt),
    .out_valid (oY_valid)
  );

  // Row sequencer with registered handshakes, weights and sample output
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state    <= S_IDLE;
      cnt      <= '0;
      oW1      <= '0;
      oW2      <= '0;
      oW3      <= '0;
      oW4      <= '0;
      oW5      <= '0;
      oX       <= '0;
      oW_ready <= 1'b0;
      oX_ready <= 1'b0;
      oBusy    <= 1'b0;
      oDone    <= 1'b0;
      oErr     <= 1'b0;
`ifdef PE5_ROW_CTRL_BIAS_EN
      oPsum_init <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          oDone <= 1'b0;
          if (iStart) begin
            state    <= S_LOAD_W;
            cnt      <= '0;
            oErr     <= 1'b0;
            oW_ready <= 1'b1;
            oBusy    <= 1'b1;
          end
        end

        S_LOAD_W: begin
          if (iW_valid) begin
            if (bias_beat_c) begin
`ifdef PE5_ROW_CTRL_BIAS_EN
              oPsum_init <= {{(PSUM_W-DATA_W){iW_data[DATA_W-1]}}, iW_data};
`endif
            end else begin
              oW5 <= oW4;
              oW4 <= oW3;
              oW3 <= oW2;
              oW2 <= oW1;
              oW1 <= iW_data;
            end
            if (cnt == CNT_W'(LOAD_BEATS - 1)) begin
              state    <= S_RUN;
              cnt      <= '0;
              oW_ready <= 1'b0;
              oX_ready <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end

        S_RUN: begin
          // The row cannot stall, so a missing sample becomes a zero slot
          if (iX_valid) begin
            oX <= iX_data;
          end else begin
            oX   <= '0;
            oErr <= 1'b1;
          end
          if (cnt == CNT_W'(LEN - 1)) begin
            state    <= S_DRAIN;
            cnt      <= '0;
            oX_ready <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_DRAIN: begin
          oX <= '0;
          if (cnt == CNT_W'(LAT)) begin
            state <= S_DONE;
            cnt   <= '0;
            oDone <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          oDone <= 1'b0;
          oBusy <= 1'b0;
        end

        default: begin
          state    <= S_IDLE;
          cnt      <= '0;
          oW_ready <= 1'b0;
          oX_ready <= 1'b0;
          oBusy    <= 1'b0;
          oDone    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe5_row_ctrl.sv
// Self-checking bench for pe5_row_ctrl. Expected result-valid and done
// cycles are scheduled from the sample timing rules; weights, samples,
// error flag and bias are predicted from the words the bench itself sent.
module tb_pe5_row_ctrl;

  localparam int LEN   = 32;
  localparam int TAPS  = 5;
  localparam int LAT   = 5;
  localparam int CNT_W = 6;
`ifdef PE5_ROW_CTRL_BIAS_EN
  localparam int NBEATS = TAPS + 1;
`else
  localparam int NBEATS = TAPS;
`endif

  logic              iCLK;
  logic              iRST;
  logic              iStart;
  logic signed [7:0] iW_data;
  logic              iW_valid;
  logic              oW_ready;
  logic signed [7:0] iX_data;
  logic              iX_valid;
  logic              oX_ready;
  logic signed [7:0] oW1, oW2, oW3, oW4, oW5;
  logic signed [7:0] oX;
  logic signed [15:0] oPsum_init;
  logic              oY_valid;
  logic              oBusy;
  logic              oDone;
  logic              oErr;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ycount   = 0;
  bit exp_y    [int];
  bit exp_done [int];
  logic signed [7:0]  w [6];
  logic signed [15:0] exp_psum = '0;

  pe5_row_ctrl #(.LEN(LEN), .LAT(LAT), .CNT_W(CNT_W)) dut (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .iStart     (iStart),
    .iW_data    (iW_data),
    .iW_valid   (iW_valid),
    .oW_ready   (oW_ready),
    .iX_data    (iX_data),
    .iX_valid   (iX_valid),
    .oX_ready   (oX_ready),
    .oW1        (oW1),
    .oW2        (oW2),
    .oW3        (oW3),
    .oW4        (oW4),
    .oW5        (oW5),
    .oX         (oX),
    .oPsum_init (oPsum_init),
    .oY_valid   (oY_valid),
    .oBusy      (oBusy),
    .oDone      (oDone),
    .oErr       (oErr)
  );

  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance to the next mid-cycle sample point and check the scheduled outputs
  task automatic step();
    @(negedge iCLK);
    cyc++;
    chk("y_valid", {31'b0, oY_valid}, exp_y.exists(cyc) ? 32'd1 : 32'd0);
    chk("done", {31'b0, oDone}, exp_done.exists(cyc) ? 32'd1 : 32'd0);
    if (oY_valid === 1'b1) ycount++;
  endtask

  task automatic check_weights(input string tag);
    chk({tag, "_w5"}, oW5, w[0]);
    chk({tag, "_w4"}, oW4, w[1]);
    chk({tag, "_w3"}, oW3, w[2]);
    chk({tag, "_w2"}, oW2, w[3]);
    chk({tag, "_w1"}, oW1, w[4]);
    chk({tag, "_psum"}, oPsum_init, exp_psum);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_w1"}, oW1, 32'd0);
    chk({tag, "_w5"}, oW5, 32'd0);
    chk({tag, "_x"}, oX, 32'd0);
    chk({tag, "_psum"}, oPsum_init, 32'd0);
    chk({tag, "_wrdy"}, {31'b0, oW_ready}, 32'd0);
    chk({tag, "_xrdy"}, {31'b0, oX_ready}, 32'd0);
    chk({tag, "_yv"}, {31'b0, oY_valid}, 32'd0);
    chk({tag, "_busy"}, {31'b0, oBusy}, 32'd0);
    chk({tag, "_done"}, {31'b0, oDone}, 32'd0);
    chk({tag, "_err"}, {31'b0, oErr}, 32'd0);
  endtask

  // One row: start, load weights (with random gaps), stream LEN slots, drain.
  // bubble: slot index with iX_valid low (-1 none); abort_at: slot index at
  // which reset is asserted (-1 none); seq: weights 1..5 and x=1..LEN;
  // poke: drive iStart/iW_valid in RUN and iX_valid in LOAD_W.
  task automatic run_row(input int bubble, input int abort_at, input bit seq, input bit poke);
    logic signed [7:0] d;
    logic signed [7:0] ex;
    bit v;
    int k;
    int gaps;
    ycount = 0;
    for (int j = 0; j < 6; j++) w[j] = seq ? 8'(j + 1) : 8'($urandom);
    if (seq) w[5] = -8'sd3;
`ifdef PE5_ROW_CTRL_BIAS_EN
    exp_psum = {{8{w[5][7]}}, w[5]};
`else
    exp_psum = '0;
`endif

    iStart = 1'b1;
    step();
    iStart = 1'b0;
    chk("load_busy", {31'b0, oBusy}, 32'd1);
    chk("load_wrdy", {31'b0, oW_ready}, 32'd1);
    chk("load_xrdy", {31'b0, oX_ready}, 32'd0);
    chk("start_clr_err", {31'b0, oErr}, 32'd0);

    k = 0;
    gaps = 0;
    while (k < NBEATS) begin
      if (k > 0 && gaps < 3 && $urandom_range(0, 2) == 0) begin
        iW_valid = 1'b0;
        iW_data  = 8'($urandom);
        gaps++;
      end else begin
        iW_valid = 1'b1;
        iW_data  = w[k];
        k++;
      end
      if (poke) begin
        iX_valid = 1'b1;
        iX_data  = 8'($urandom);
      end
      step();
    end
    iW_valid = 1'b0;
    iX_valid = 1'b0;
    chk("run_xrdy", {31'b0, oX_ready}, 32'd1);
    chk("run_wrdy", {31'b0, oW_ready}, 32'd0);
    chk("load_x_ignored", oX, 32'd0);
    check_weights("loaded");

    for (int i = 0; i < LEN; i++) begin
      if (i == abort_at) begin
        iRST = 1'b1;
        #1;
        check_zero("abort");
        exp_y.delete();
        exp_done.delete();
        iX_valid = 1'b0;
        iW_valid = 1'b0;
        iStart   = 1'b0;
        step();
        step();
        iRST = 1'b0;
        repeat (LEN + LAT) step();
        chk("abort_idle_busy", {31'b0, oBusy}, 32'd0);
        exp_psum = '0;
        return;
      end
      v = (i != bubble);
      d = seq ? 8'(i + 1) : 8'($urandom);
      iX_valid = v;
      iX_data  = d;
      if (poke) begin
        iStart   = 1'b1;
        iW_valid = 1'b1;
        iW_data  = 8'($urandom);
      end
      if (i >= TAPS - 1) exp_y[cyc + 1 + LAT] = 1'b1;
      if (i == LEN - 1) exp_done[cyc + LAT + 2] = 1'b1;
      step();
      ex = v ? d : 8'sd0;
      chk("x", oX, ex);
      if (!v) chk("bubble_err", {31'b0, oErr}, 32'd1);
    end
    iX_valid = 1'b0;
    iW_valid = 1'b0;
    iStart   = 1'b0;

    repeat (LAT + 1) step();
    chk("done_busy", {31'b0, oBusy}, 32'd1);
    step();
    chk("idle_busy", {31'b0, oBusy}, 32'd0);
    chk("idle_x", oX, 32'd0);
    chk("row_err", {31'b0, oErr}, (bubble >= 0) ? 32'd1 : 32'd0);
    chk("y_count", ycount, LEN - TAPS + 1);
    check_weights("held");
  endtask

  initial begin
    iRST     = 1'b1;
    iStart   = 1'b0;
    iW_data  = '0;
    iW_valid = 1'b0;
    iX_data  = '0;
    iX_valid = 1'b0;
    for (int j = 0; j < 6; j++) w[j] = '0;

    step();
    step();
    check_zero("reset");
    iRST = 1'b0;
    step();

    run_row(-1, -1, 1'b1, 1'b0);
    run_row(-1, 10, 1'b0, 1'b0);
    run_row(7, -1, 1'b0, 1'b0);
    run_row(-1, -1, 1'b0, 1'b1);
    run_row(LEN - 1, -1, 1'b0, 1'b1);
    run_row(0, -1, 1'b0, 1'b0);
    run_row(-1, -1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
